// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// full byte-enable constant and the byte-lane merge used on stores.
package dmem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] BE_FULL = 4'hF;

   function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  be);
      logic [31:0] merged;
      if (be == BE_FULL) return new_word;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the CPU MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array with byte-enable writes and a registered read port.
// The read register returns zero for stores and when cleared.
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              acc,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   input  logic [3:0]        be,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W] = '{default: '0};

   always_ff @(posedge clk) begin
      if (acc && we) mem[idx] <= merge_be(mem[idx], wdata, be);
      if (clr)      rdata <= '0;
      else if (acc) rdata <= we ? 32'd0 : mem[idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response pulse LATENCY cycles
// after acceptance. Define DMEM_ALIGN_CHECK_EN to flag misaligned/out-of-range addresses.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   dmem_responder_if.slave  bus
);

   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
   end

   state_t            state_q, state_d;
   logic [3:0]        cnt_q;
   logic              accept, enter_resp, req_err;
   logic              we_q, err_q, rsp_err_q;
   logic [ADDR_W-1:0] idx_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic              acc_we, acc_err;
   logic [ADDR_W-1:0] acc_idx;
   logic [31:0]       acc_wdata;
   logic [3:0]        acc_be;
   logic              unused_addr;

   assign unused_addr = ^bus.req_addr;

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                    ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
`else
   assign req_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept)                      cnt_q <= 4'(LATENCY - 1);
         else if (state_q == WAIT && en)  cnt_q <= cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= bus.req_we;
         idx_q   <= bus.req_addr[ADDR_W+1:2];
         wdata_q <= bus.req_wdata;
         be_q    <= bus.req_be;
         err_q   <= req_err;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)           rsp_err_q <= 1'b0;
      else if (enter_resp) rsp_err_q <= acc_err;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, RESP: state_d = accept ? ((LATENCY == 1) ? RESP : WAIT) : IDLE;
         WAIT:       if (en && cnt_q == 4'd1) state_d = RESP;
         default:    state_d = IDLE;
      endcase
   end

   // With LATENCY==1 the request enters RESP on its own accept edge, so the
   // array access must use the live request rather than the latched copy.
   always_comb begin
      bus.req_ready = en & ~reset & (state_q == IDLE || state_q == RESP);
      accept        = bus.req_valid & bus.req_ready;
      enter_resp    = (state_d == RESP) & ~reset;
      acc_we        = accept ? bus.req_we    : we_q;
      acc_idx       = accept ? bus.req_addr[ADDR_W+1:2] : idx_q;
      acc_wdata     = accept ? bus.req_wdata : wdata_q;
      acc_be        = accept ? bus.req_be    : be_q;
      acc_err       = accept ? req_err       : err_q;
   end

   dmem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .clr   (reset | (enter_resp & acc_err)),
      .acc   (enter_resp & ~acc_err),
      .we    (acc_we),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .be    (acc_be),
      .rdata (bus.rsp_rdata)
   );

   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a
// word-array reference model, a negedge monitor pops and compares them.
module tb_dmem_responder;

   localparam int ADDR_W  = 8;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 1 << ADDR_W;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc_cyc;
      logic        we;
      int          idx;
      logic [31:0] old;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic en = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   int   front_stall = 0;
   exp_t sb[$];
   logic [31:0] ref_mem [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder_if bus ();

   dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .bus   (bus)
   );

   function automatic logic addr_err(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
`else
      return (a == 32'hFFFF_FFFF) && (a != a);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_expected(input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
      exp_t e;
      logic [31:0] mask;
      e.idx     = int'((addr / 4) % DEPTH);
      e.err     = addr_err(addr);
      e.we      = we;
      e.old     = ref_mem[e.idx];
      e.acc_cyc = cyc;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (we) begin
         e.rdata = 32'd0;
         if (!e.err) ref_mem[e.idx] = (ref_mem[e.idx] & ~mask) | (wdata & mask);
      end else begin
         e.rdata = e.err ? 32'd0 : ref_mem[e.idx];
      end
      sb.push_back(e);
   endtask

   task automatic flush_pending();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_back();
         if (e.we && !e.err) ref_mem[e.idx] = e.old;
      end
      front_stall = 0;
   endtask

   // Called just after a rising edge; returns just after the edge that accepted it.
   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
      int waited = 0;
      bit done = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      while (!done) begin
         @(negedge clk);
         if (bus.req_ready) begin
            push_expected(we, addr, wdata, be);
            done = 1;
         end else begin
            waited++;
            if (waited > 50) begin
               n_vec++;
               n_fail++;
               $display("FAIL accept_timeout: req_ready stayed 0, required 1 within 50 cycles");
               done = 1;
            end
         end
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      logic busy;
      busy = (sb.size() > 0) && !bus.rsp_valid && (sb[0].acc_cyc < cyc);
      check("req_ready", 32'(bus.req_ready), 32'(en & ~reset & ~busy));
      if (bus.rsp_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, required 0 (nothing pending, cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("rsp_rdata", bus.rsp_rdata, e.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            check("latency", 32'(cyc - e.acc_cyc), 32'(LATENCY + front_stall));
            front_stall = 0;
         end
      end else if (busy && !en) begin
         front_stall++;
      end
   end

   initial begin
      int w;
      logic [31:0] addr;
      int r;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 32'd0;
      bus.req_wdata = 32'd0;
      bus.req_be    = 4'd0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Basic store then load
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      do_req(1'b0, 32'h10, 32'd0, 4'h0);

      // Byte enables
      do_req(1'b1, 32'h20, 32'h11223344, 4'hF);
      do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
      do_req(1'b0, 32'h20, 32'd0, 4'h0);
      do_req(1'b1, 32'h20, 32'h99999999, 4'b0000);
      do_req(1'b0, 32'h20, 32'd0, 4'h0);

      // Back-to-back loads with req_valid held high
      do_req(1'b0, 32'h10, 32'd0, 4'h0);
      do_req(1'b0, 32'h20, 32'd0, 4'h0);
      do_req(1'b0, 32'h24, 32'd0, 4'h0);

      // Enable dropped for three cycles during WAIT
      do_req(1'b0, 32'h10, 32'd0, 4'h0);
      en = 1'b0;
      repeat (3) @(posedge clk);
      #1 en = 1'b1;

      // Reset one cycle after accepting a store drops it
      do_req(1'b1, 32'h30, 32'h55, 4'hF);
      reset = 1'b1;
      flush_pending();
      @(posedge clk);
      #1 reset = 1'b0;
      do_req(1'b0, 32'h30, 32'd0, 4'h0);

      // Misaligned / out-of-range addresses
      do_req(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
      do_req(1'b1, 32'h32, 32'hFFFFFFFF, 4'hF);
      do_req(1'b0, 32'h30, 32'd0, 4'h0);
      do_req(1'b0, 32'h400, 32'd0, 4'h0);

      // Randomised traffic with enable stalls and idle gaps
      for (int n = 0; n < 80; n++) begin
         r = int'($urandom_range(0, 9));
         addr = 32'($urandom_range(0, 15)) * 32'd4;
         if (r == 7) addr = addr + 32'($urandom_range(1, 3));
         if (r == 8) addr = addr + 32'h400 * 32'($urandom_range(1, 4));
         if (r == 9) addr = $urandom;
         do_req(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1 en = 1'b1;
         end
         if ($urandom_range(0, 4) == 0) begin
            repeat (2) @(posedge clk);
            #1;
         end
      end

      w = 0;
      while (sb.size() > 0 && w < 50) begin
         @(posedge clk);
         w++;
      end
      n_vec++;
      if (sb.size() > 0) begin
         n_fail++;
         $display("FAIL drain: got %0d responses outstanding, required 0", sb.size());
      end
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
